rectifier_adc_ctrl: RTL
=======================

# rectifier_adc_ctrl

Conversion controller for the two 8-bit rectifier ADCs (battery voltage and current), one instance per converter. It replaces the free-running `clk_100k` drive on `ADC_BAT_V_CONVST`/`ADC_BAT_I_CONVST`. It acts as the initiator of the CONVST/EOC exchange: it starts each conversion, waits for end-of-conversion, and latches the 8-bit result. It also flags missing responses and optionally produces a block average for the 7-segment display and protection logic.

## Interface
Parameters:
- `CONV_PERIOD`, 1000 — `i_clock` cycles between conversion starts (100 kHz at 100 MHz).
- `CONVST_WIDTH`, 10 — cycles `o_adc_convst` is held high per conversion.
- `EOC_TIMEOUT`, 500 — maximum cycles spent waiting for EOC. Must satisfy `CONVST_WIDTH + EOC_TIMEOUT + 4 < CONV_PERIOD`.
- `AVG_LOG2`, 3 — log2 of the number of samples per average (8 samples).

Ports:
- `i_clock` in 1 — system clock (`clk_100M`).
- `i_RESET` in 1 — reset; synchronous, active-high.
- `i_enable` in 1 — run conversions while high.
- `i_adc_data` in 8 — ADC parallel output, unsigned.
- `i_adc_eoc` in 1 — ADC end-of-conversion; asynchronous, active-low.
- `o_adc_convst` out 1 — conversion start to the ADC; a rising edge starts a conversion.
- `o_sample` out 8 — last valid sample.
- `o_sample_valid` out 1 — one-cycle pulse when `o_sample` updates.
- `o_avg` out 8 — last block average.
- `o_avg_valid` out 1 — one-cycle pulse when `o_avg` updates.
- `o_timeout` out 1 — sticky flag: an EOC was missed.
- `o_busy` out 1 — high in START, WAIT_EOC and LATCH.

## Operation
- `i_adc_eoc` passes through a 2-FF synchronizer, giving `eoc_s`. Only `eoc_s` is used internally.
- FSM states: IDLE, START, WAIT_EOC, LATCH, HOLD.
  - IDLE: period counter is 0. When `i_enable` is 1, go to START.
  - START: `o_adc_convst` = 1. Runs for `CONVST_WIDTH` cycles, then goes to WAIT_EOC.
  - WAIT_EOC: a timeout counter runs.
    - If `eoc_s` = 0, go to LATCH.
    - If the counter reaches `EOC_TIMEOUT` first, set `o_timeout` and go to HOLD without a sample.
    - If EOC is already low when WAIT_EOC is entered, it is accepted immediately.
  - LATCH: register `i_adc_data` into `o_sample`, pulse `o_sample_valid`, go to HOLD.
  - HOLD: when the period counter reaches `CONV_PERIOD-1`, go to START.
- Period counter: cleared on every entry to START and incremented every cycle outside IDLE. Conversion starts are therefore exactly `CONV_PERIOD` cycles apart.
- Averaging: each valid sample is added into an accumulator of width 8+`AVG_LOG2`, with a sample count.
  - After 2^`AVG_LOG2` samples: `o_avg` = accumulator >> `AVG_LOG2` (truncating), `o_avg_valid` pulses, and the accumulator and count clear.
  - Timed-out conversions contribute nothing and do not advance the count.
- `i_enable` falling in any state:
  - Next cycle enters IDLE with `o_adc_convst` = 0.
  - Accumulator and count clear; `o_timeout` clears.
  - `o_sample` and `o_avg` hold their values.
  - No valid pulse is produced for an in-flight conversion.
- If `i_enable` drops in the same cycle as LATCH, the latch completes and that `o_sample_valid` pulse is emitted; the FSM then enters IDLE.

## Timing
- Reset values: every output is 0; the FSM is in IDLE; all counters are 0.
- `i_enable` sampled high at edge n: START is entered at n+1, and `o_adc_convst` is high from n+1 through n+`CONVST_WIDTH`.
- EOC-to-sample latency: with `i_adc_eoc` falling before edge t, `eoc_s` = 0 at t+2, LATCH at t+3, and `o_sample`/`o_sample_valid` are valid after edge t+3.
- `o_avg_valid` is asserted the cycle after the `o_sample_valid` of the final sample in a block.
- `o_timeout` sets the cycle after the `EOC_TIMEOUT`-th WAIT_EOC cycle. It clears only on `i_RESET` or on `i_enable` low.
- Reset asserted mid-conversion takes effect on the next edge; `o_adc_convst` drops immediately.

## Configuration
- `RECT_ADC_AVG_EN`:
  - Defined: the averaging accumulator, sample count, `o_avg` and `o_avg_valid` are built as described.
  - Undefined: no accumulator logic is generated, and `o_avg`/`o_avg_valid` are tied to 0.
  - Sample path, FSM and timeout behaviour are identical in both builds.

## Test plan
- Basic conversion: reset, then `i_enable` = 1. ADC model pulls EOC low 200 cycles after the CONVST rise, with data 0x5A. Required: `o_sample` = 0x5A with a one-cycle valid pulse 3 cycles after EOC falls; next CONVST rise exactly 1000 cycles after the first.
- Averaging: 8 conversions with data 10, 20, …, 80. Required: `o_avg` = 45 (360>>3) and `o_avg_valid` one cycle after the 8th sample valid. Without `RECT_ADC_AVG_EN`, `o_avg_valid` never pulses.
- Timeout: EOC held high. Required: `o_timeout` = 1 after 10+500 cycles, no `o_sample_valid`, next CONVST still on the 1000-cycle grid; a later good sample does not clear the flag.
- Timeout excluded from average: 3 good samples of 100, 1 timeout, then 5 good samples of 100. Required: a single `o_avg_valid` with `o_avg` = 100, after the 8th good sample.
- Disable mid-WAIT_EOC: drop `i_enable` 50 cycles into WAIT_EOC, then let EOC fall. Required: no valid pulse, `o_adc_convst` = 0, `o_busy` = 0 the next cycle; re-enabling restarts the average count from 0.
- Reset mid-START: assert `i_RESET` during CONVST high. Required: all outputs 0 on the next edge, FSM in IDLE.

Source files
------------

// File: rtl/rectifier_adc_ctrl.sv
// rectifier_adc_ctrl: CONVST/EOC initiator for one 8-bit rectifier ADC, with optional block average (RECT_ADC_AVG_EN).
// Latency: CONVST every CONV_PERIOD cycles; sample valid 3 cycles after the edge following EOC falling; average 1 cycle after the last sample.
// Backpressure: none; results are pulses, a missing EOC sets a sticky timeout, i_enable low aborts to IDLE.
module rectifier_adc_ctrl #(
  parameter int CONV_PERIOD  = 1000,
  parameter int CONVST_WIDTH = 10,
  parameter int EOC_TIMEOUT  = 500,
  parameter int AVG_LOG2     = 3
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic       i_enable,
  input  logic [7:0] i_adc_data,
  input  logic       i_adc_eoc,
  output logic       o_adc_convst,
  output logic [7:0] o_sample,
  output logic       o_sample_valid,
  output logic [7:0] o_avg,
  output logic       o_avg_valid,
  output logic       o_timeout,
  output logic       o_busy
);

  localparam int PW = $clog2(CONV_PERIOD);
  localparam int TW = $clog2(EOC_TIMEOUT + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(CONV_PERIOD - 1);
  localparam logic [PW-1:0] CW_LAST  = PW'(CONVST_WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(EOC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_EOC,
    S_LATCH,
    S_HOLD
  } state_t;

  state_t        state_q;
  logic [PW-1:0] per_q;
  logic [TW-1:0] to_q;
  logic          convst_q;
  logic [7:0]    sample_q;
  logic          sample_vld_q;
  logic          timeout_q;
  logic          busy_q;
  logic          eoc_meta_q;
  logic          eoc_s_q;

  // Two-flop synchronizer for the asynchronous, active-low EOC; idles high.
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      eoc_meta_q <= 1'b1;
      eoc_s_q    <= 1'b1;
    end else begin
      eoc_meta_q <= i_adc_eoc;
      eoc_s_q    <= eoc_meta_q;
    end
  end

  // Conversion sequencer; the period counter runs outside IDLE so starts stay on a fixed grid.
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      state_q      <= S_IDLE;
      per_q        <= '0;
      to_q         <= '0;
      convst_q     <= 1'b0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sample_vld_q <= 1'b0;
      if (state_q != S_IDLE) begin
        per_q <= per_q + 1'b1;
      end
      if (!i_enable) begin
        // A conversion already in LATCH still delivers its sample.
        if (state_q == S_LATCH) begin
          sample_q     <= i_adc_data;
          sample_vld_q <= 1'b1;
        end
        state_q   <= S_IDLE;
        per_q     <= '0;
        to_q      <= '0;
        convst_q  <= 1'b0;
        timeout_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q  <= S_START;
            per_q    <= '0;
            convst_q <= 1'b1;
            busy_q   <= 1'b1;
          end
          S_START: begin
            if (per_q == CW_LAST) begin
              state_q  <= S_WAIT_EOC;
              convst_q <= 1'b0;
              to_q     <= '0;
            end
          end
          S_WAIT_EOC: begin
            if (!eoc_s_q) begin
              state_q <= S_LATCH;
            end else if (to_q == TO_LAST) begin
              state_q   <= S_HOLD;
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              to_q <= to_q + 1'b1;
            end
          end
          S_LATCH: begin
            sample_q     <= i_adc_data;
            sample_vld_q <= 1'b1;
            state_q      <= S_HOLD;
            busy_q       <= 1'b0;
          end
          S_HOLD: begin
            if (per_q == PER_LAST) begin
              state_q  <= S_START;
              per_q    <= '0;
              convst_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            per_q    <= '0;
            convst_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_adc_convst   = convst_q;
  assign o_sample       = sample_q;
  assign o_sample_valid = sample_vld_q;
  assign o_timeout      = timeout_q;
  assign o_busy         = busy_q;

`ifdef RECT_ADC_AVG_EN
  logic [7+AVG_LOG2:0]  acc_q;
  logic [7+AVG_LOG2:0]  acc_sum;
  logic [AVG_LOG2-1:0]  cnt_q;
  logic [7:0]           avg_q;
  logic                 avg_vld_q;

  assign acc_sum = acc_q + {{AVG_LOG2{1'b0}}, sample_q};

  // Block averager fed by the registered sample pulse; a full block is a power of two, so divide is a shift.
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      avg_vld_q <= 1'b0;
      if (!i_enable) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (sample_vld_q) begin
        if (cnt_q == {AVG_LOG2{1'b1}}) begin
          avg_q     <= acc_sum[7+AVG_LOG2:AVG_LOG2];
          avg_vld_q <= 1'b1;
          acc_q     <= '0;
          cnt_q     <= '0;
        end else begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign o_avg       = avg_q;
  assign o_avg_valid = avg_vld_q;
`else
  assign o_avg       = 8'd0;
  assign o_avg_valid = 1'b0;
`endif

endmodule
